alu_op_sequencer: RTL and testbench

Parametrised ALU control-and-execute stage: accepts decoded instruction fields (aluOp, funct7, funct3) plus two WIDTH-bit operands over a valid/ready handshake, decodes them to an extended 4-bit ALU control code, and executes. Single-cycle ops complete in one cycle; MUL runs an iterative shift-add sequence. Sits between the instruction decoder and writeback/branch logic of the 64-bit datapath, replacing the purely combinational ALU-control decode.

---
 rtl/alu_pkg.sv | 50 +++++
 rtl/alu_decode.sv | 41 ++++
 rtl/alu_op_sequencer.sv | 145 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU control-and-execute stage: control codes,
// alu_op encodings, funct7 qualifiers and the sequencer state type.
package alu_pkg;

  // 4-bit extended ALU control codes
  localparam logic [3:0] CTRL_AND     = 4'b0000;
  localparam logic [3:0] CTRL_OR      = 4'b0001;
  localparam logic [3:0] CTRL_ADD     = 4'b0010;
  localparam logic [3:0] CTRL_XOR     = 4'b0011;
  localparam logic [3:0] CTRL_SLL     = 4'b0100;
  localparam logic [3:0] CTRL_SRL     = 4'b0101;
  localparam logic [3:0] CTRL_SUB     = 4'b0110;
  localparam logic [3:0] CTRL_SLT     = 4'b0111;
  localparam logic [3:0] CTRL_SRA     = 4'b1000;
  localparam logic [3:0] CTRL_SLTU    = 4'b1001;
  localparam logic [3:0] CTRL_MUL     = 4'b1010;
  localparam logic [3:0] CTRL_ILLEGAL = 4'b1111;

  // alu_op encodings coming from the main decoder
  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  // funct7 qualifiers
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

  // funct3 mapping shared by R-type (funct7 BASE) and I-type
  function automatic logic [3:0] base_ctrl(input logic [2:0] funct3);
    case (funct3)
      3'b000:  base_ctrl = CTRL_ADD;
      3'b001:  base_ctrl = CTRL_SLL;
      3'b010:  base_ctrl = CTRL_SLT;
      3'b011:  base_ctrl = CTRL_SLTU;
      3'b100:  base_ctrl = CTRL_XOR;
      3'b101:  base_ctrl = CTRL_SRL;
      3'b110:  base_ctrl = CTRL_OR;
      default: base_ctrl = CTRL_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of (alu_op, funct7, funct3) to the 4-bit ALU control code.
module alu_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  output logic [3:0] alu_ctrl
);

  // Map instruction fields to a control code; unknown encodings fall to ILLEGAL
  always_comb begin
    alu_ctrl = CTRL_ILLEGAL;
    case (alu_op)
      ALUOP_MEM:    alu_ctrl = CTRL_ADD;
      ALUOP_BRANCH: alu_ctrl = CTRL_SUB;
      ALUOP_RTYPE: begin
        if (funct7 == F7_BASE) begin
          alu_ctrl = base_ctrl(funct3);
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000)      alu_ctrl = CTRL_SUB;
          else if (funct3 == 3'b101) alu_ctrl = CTRL_SRA;
        end else if (funct7 == F7_MULDIV) begin
          if (funct3 == 3'b000) alu_ctrl = CTRL_MUL;
        end
      end
      default: begin
        // I-type: only the shift immediates carry a funct7 qualifier
        if (funct3 == 3'b001) begin
          if (funct7 == F7_BASE) alu_ctrl = CTRL_SLL;
        end else if (funct3 == 3'b101) begin
          if (funct7 == F7_BASE)     alu_ctrl = CTRL_SRL;
          else if (funct7 == F7_ALT) alu_ctrl = CTRL_SRA;
        end else begin
          alu_ctrl = base_ctrl(funct3);
        end
      end
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU control-and-execute stage. Single-cycle ops are computed at accept and
// presented in DONE; MUL runs an iterative shift-add over MUL_STEP bits/cycle.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The source holds its request until accepted; the result is held in
// DONE, unchanged, until out_ready is seen high.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [6:0]       funct7,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [3:0]       alu_ctrl,
  output logic             illegal,
  output logic [1:0]       dbg_state
);

  localparam int SH_W  = $clog2(WIDTH);
  localparam int ITERS = WIDTH / MUL_STEP;
  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

  alu_state_t       state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand, mplier, acc;
  logic [WIDTH-1:0] exec_result, mul_partial, mul_sum;
  logic [3:0]       code;
  logic [SH_W-1:0]  shamt;
  logic             accept, is_mul, last_iter;

  alu_decode u_decode (
    .alu_op   (alu_op),
    .funct7   (funct7),
    .funct3   (funct3),
    .alu_ctrl (code)
  );

  assign in_ready  = (state == ST_IDLE) || (state == ST_DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (code == CTRL_MUL);
  assign last_iter = (cnt == CNT_W'(ITERS - 1));
  assign out_valid = (state == ST_DONE);
  assign dbg_state = state;
  assign shamt     = op_b[SH_W-1:0];

  // Single-cycle execute straight from the request operands
  always_comb begin
    exec_result = '0;
    case (code)
      CTRL_AND:  exec_result = op_a & op_b;
      CTRL_OR:   exec_result = op_a | op_b;
      CTRL_ADD:  exec_result = op_a + op_b;
      CTRL_XOR:  exec_result = op_a ^ op_b;
      CTRL_SLL:  exec_result = op_a << shamt;
      CTRL_SRL:  exec_result = op_a >> shamt;
      CTRL_SUB:  exec_result = op_a - op_b;
      CTRL_SLT:  exec_result = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      CTRL_SRA:  exec_result = $signed(op_a) >>> shamt;
      CTRL_SLTU: exec_result = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      default:   exec_result = '0;
    endcase
  end

  // Partial product for the low MUL_STEP multiplier bits of this iteration
  always_comb begin
    mul_partial = '0;
    for (int j = 0; j < MUL_STEP; j++) begin
      if (mplier[j]) mul_partial = mul_partial + (mcand << j);
    end
    mul_sum = acc + mul_partial;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = is_mul ? ST_MUL : ST_DONE;
      ST_MUL:  if (last_iter) state_next = ST_DONE;
      ST_DONE: begin
        if (out_ready) begin
          if (accept) state_next = is_mul ? ST_MUL : ST_DONE;
          else        state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Operand latch, shift-add iteration and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      result   <= '0;
      zero     <= 1'b0;
      alu_ctrl <= 4'b0000;
      illegal  <= 1'b0;
    end else if (accept) begin
      if (is_mul) begin
        mcand  <= op_a;
        mplier <= op_b;
        acc    <= '0;
        cnt    <= '0;
      end else begin
        result   <= exec_result;
        zero     <= (exec_result == '0);
        alu_ctrl <= code;
        illegal  <= (code == CTRL_ILLEGAL);
      end
    end else if (state == ST_MUL) begin
      acc    <= mul_sum;
      mcand  <= mcand << MUL_STEP;
      mplier <= mplier >> MUL_STEP;
      cnt    <= cnt + 1'b1;
      if (last_iter) begin
        cnt      <= '0;
        result   <= mul_sum;
        zero     <= (mul_sum == '0);
        alu_ctrl <= CTRL_MUL;
        illegal  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: table-driven vectors, a random sweep against
// a reference model, and hand-written multi-cycle sequences (MUL latency,
// backpressure/streaming, reset during MUL).
module tb_alu_op_sequencer;

  localparam int W  = 64;
  localparam int EW = W + 6;  // {zero, illegal, ctrl[3:0], result}

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   alu_op;
  logic [6:0]   funct7;
  logic [2:0]   funct3;
  logic [W-1:0] op_a, op_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic [3:0]   alu_ctrl;
  logic         illegal;
  logic [1:0]   dbg_state;

  alu_op_sequencer #(.WIDTH(W), .MUL_STEP(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct7    (funct7),
    .funct3    (funct3),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .alu_ctrl  (alu_ctrl),
    .illegal   (illegal),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int            pop_cyc[$];
  int            n_checks = 0;
  int            n_fail   = 0;

  typedef struct {
    logic [1:0]   aop;
    logic [6:0]   f7;
    logic [2:0]   f3;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   ctrl;
    logic         ill;
  } vec_t;

  vec_t vecs[24];
  int   nv = 0;

  function automatic logic [EW-1:0] pack(input logic [W-1:0] res, input logic [3:0] ctrl,
                                          input logic ill);
    pack = {(res == '0), ill, ctrl, res};
  endfunction

  // Reference model of the control decode
  function automatic logic [3:0] m_ctrl(input logic [1:0] aop, input logic [6:0] f7,
                                         input logic [2:0] f3);
    logic [3:0] basemap;
    case (f3)
      3'd0: basemap = 4'b0010;
      3'd1: basemap = 4'b0100;
      3'd2: basemap = 4'b0111;
      3'd3: basemap = 4'b1001;
      3'd4: basemap = 4'b0011;
      3'd5: basemap = 4'b0101;
      3'd6: basemap = 4'b0001;
      default: basemap = 4'b0000;
    endcase
    if (aop == 2'b00) return 4'b0010;
    if (aop == 2'b01) return 4'b0110;
    if (aop == 2'b10) begin
      if (f7 == 7'h00) return basemap;
      if (f7 == 7'h20 && f3 == 3'd0) return 4'b0110;
      if (f7 == 7'h20 && f3 == 3'd5) return 4'b1000;
      if (f7 == 7'h01 && f3 == 3'd0) return 4'b1010;
      return 4'b1111;
    end
    if (f3 == 3'd1) return (f7 == 7'h00) ? 4'b0100 : 4'b1111;
    if (f3 == 3'd5) begin
      if (f7 == 7'h00) return 4'b0101;
      if (f7 == 7'h20) return 4'b1000;
      return 4'b1111;
    end
    return basemap;
  endfunction

  // Reference model of the execute step
  function automatic logic [W-1:0] m_res(input logic [3:0] c, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [5:0] s;
    s = b[5:0];
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a ^ b;
      4'b0100: return a << s;
      4'b0101: return a >> s;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'b1000: return $signed(a) >>> s;
      4'b1001: return (a < b) ? 64'd1 : 64'd0;
      4'b1010: return a * b;
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [1:0] aop, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] res, input logic [3:0] ctrl, input logic ill);
    vecs[nv] = '{aop, f7, f3, a, b, res, ctrl, ill};
    nv++;
  endtask

  // ---------------- driver tasks ----------------
  // Entered just after a rising edge; leaves just after the accepting edge.
  task automatic send(input logic [1:0] aop, input logic [6:0] f7, input logic [2:0] f3,
                      input logic [W-1:0] a, input logic [W-1:0] b, input logic [EW-1:0] e);
    int k;
    alu_op   = aop;
    funct7   = f7;
    funct3   = f3;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    @(negedge clk);
    k = 0;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=%0b expected 1 within 200 cycles", in_ready);
    end else begin
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for every expected result to be consumed, then realign.
  task automatic drain(input string name);
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(negedge clk);
    chk(name, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus + monitor ----------------
  initial begin
    logic [1:0] aop;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [W-1:0] a, b;
    logic [3:0] c;
    int n, p0;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = '0; funct7 = '0; funct3 = '0; op_a = '0; op_b = '0;

    // Output monitor: compare every consumed result against the queue head
    fork
      forever begin
        logic [EW-1:0] e;
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
          pop_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: result=0x%h ctrl=%b with nothing expected",
                     result, alu_ctrl);
          end else begin
            e = exp_q.pop_front();
            chk("out_result",  result,       e[W-1:0]);
            chk("out_ctrl",    64'(alu_ctrl), 64'(e[W+3:W]));
            chk("out_illegal", 64'(illegal),  64'(e[W+4]));
            chk("out_zero",    64'(zero),     64'(e[W+5]));
          end
        end
      end
    join_none

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result",    result,         64'd0);
    chk("rst_zero",      64'(zero),      64'd0);
    chk("rst_ctrl",      64'(alu_ctrl),  64'd0);
    chk("rst_illegal",   64'(illegal),   64'd0);
    chk("rst_state",     64'(dbg_state), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // First ADD: out_valid exactly one cycle after accept
    send(2'b00, 7'h00, 3'd0, 64'd5, 64'd7, pack(64'd12, 4'b0010, 1'b0));
    @(negedge clk);
    chk("add_latency_valid", 64'(out_valid), 64'd1);
    drain("drain_first_add");

    // Directed vector table
    add_vec(2'b01, 7'h00, 3'd0, 64'h1234, 64'h1234, 64'd0, 4'b0110, 1'b0);
    add_vec(2'b10, 7'h20, 3'd0, 64'd3, 64'd7, 64'hFFFF_FFFF_FFFF_FFFC, 4'b0110, 1'b0);
    add_vec(2'b10, 7'h20, 3'd5, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 4'b1000, 1'b0);
    add_vec(2'b10, 7'h00, 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 4'b0111, 1'b0);
    add_vec(2'b10, 7'h00, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b1001, 1'b0);
    add_vec(2'b10, 7'h03, 3'd0, 64'd9, 64'd9, 64'd0, 4'b1111, 1'b1);
    add_vec(2'b10, 7'h00, 3'd1, 64'd1, 64'd65, 64'd2, 4'b0100, 1'b0);
    add_vec(2'b10, 7'h00, 3'd5, 64'hF0, 64'd4, 64'h0F, 4'b0101, 1'b0);
    add_vec(2'b10, 7'h00, 3'd4, 64'hFF00, 64'h0FF0, 64'hF0F0, 4'b0011, 1'b0);
    add_vec(2'b10, 7'h00, 3'd6, 64'hF0, 64'h0F, 64'hFF, 4'b0001, 1'b0);
    add_vec(2'b10, 7'h00, 3'd7, 64'hF0, 64'h3C, 64'h30, 4'b0000, 1'b0);
    add_vec(2'b10, 7'h00, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b0010, 1'b0);
    add_vec(2'b11, 7'h20, 3'd0, 64'd3, 64'd7, 64'd10, 4'b0010, 1'b0);
    add_vec(2'b11, 7'h20, 3'd5, 64'h8000_0000_0000_0000, 64'd1, 64'hC000_0000_0000_0000, 4'b1000, 1'b0);
    add_vec(2'b11, 7'h20, 3'd1, 64'd1, 64'd1, 64'd0, 4'b1111, 1'b1);
    add_vec(2'b11, 7'h11, 3'd5, 64'd8, 64'd1, 64'd0, 4'b1111, 1'b1);
    add_vec(2'b11, 7'h5A, 3'd7, 64'hF0, 64'h3C, 64'h30, 4'b0000, 1'b0);
    add_vec(2'b10, 7'h20, 3'd1, 64'd1, 64'd1, 64'd0, 4'b1111, 1'b1);
    add_vec(2'b10, 7'h01, 3'd1, 64'd1, 64'd1, 64'd0, 4'b1111, 1'b1);
    add_vec(2'b01, 7'h01, 3'd7, 64'd10, 64'd3, 64'd7, 4'b0110, 1'b0);
    add_vec(2'b00, 7'h01, 3'd0, 64'd6, 64'd7, 64'd13, 4'b0010, 1'b0);
    add_vec(2'b10, 7'h01, 3'd0, 64'd7, 64'd6, 64'd42, 4'b1010, 1'b0);
    for (int i = 0; i < nv; i++)
      send(vecs[i].aop, vecs[i].f7, vecs[i].f3, vecs[i].a, vecs[i].b,
           pack(vecs[i].res, vecs[i].ctrl, vecs[i].ill));
    drain("drain_table");

    // Random sweep against the reference model
    for (int i = 0; i < 24; i++) begin
      aop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        2:       f7 = 7'h01;
        default: f7 = 7'($urandom_range(0, 127));
      endcase
      f3 = 3'($urandom_range(0, 7));
      a  = {$urandom, $urandom};
      b  = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 100));
      c  = m_ctrl(aop, f7, f3);
      send(aop, f7, f3, a, b, pack(m_res(c, a, b), c, c == 4'b1111));
    end
    drain("drain_random");

    // MUL: latency, in_ready low throughout, ignored in_valid pulses
    send(2'b10, 7'h01, 3'd0, 64'hFFFF_FFFF, 64'd3, pack(64'h2_FFFF_FFFD, 4'b1010, 1'b0));
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
      chk("mul_in_ready_low", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      if (n < 55) begin
        in_valid = 1'($urandom_range(0, 1));
        alu_op   = 2'b00;
        op_a     = {$urandom, $urandom};
        op_b     = {$urandom, $urandom};
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("mul_latency", 64'(n), 64'd65);
    drain("drain_mul");

    // Backpressure in DONE, then a same-cycle release + stream of 4 ADDs
    out_ready = 1'b0;
    send(2'b00, 7'h00, 3'd0, 64'd100, 64'd23, pack(64'd123, 4'b0010, 1'b0));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready",  64'(in_ready),  64'd0);
      chk("bp_result",    result,         64'd123);
      chk("bp_ctrl",      64'(alu_ctrl),  64'd2);
    end
    @(posedge clk);
    #1;
    p0 = pop_cyc.size();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      send(2'b00, 7'h00, 3'd0, 64'(i * 10 + 1), 64'(i), pack(64'(i * 11 + 1), 4'b0010, 1'b0));
    drain("drain_stream");
    chk("stream_count", 64'(pop_cyc.size() - p0), 64'd5);
    if (pop_cyc.size() - p0 == 5)
      chk("stream_back_to_back", 64'(pop_cyc[p0 + 4] - pop_cyc[p0]), 64'd4);

    // Reset in the middle of a MUL (iteration 10)
    send(2'b10, 7'h01, 3'd0, 64'd12345, 64'd678, pack(64'd8369910, 4'b1010, 1'b0));
    for (int k = 0; k < 11; k++) @(negedge clk);
    chk("mid_mul_state", 64'(dbg_state), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_state",     64'(dbg_state), 64'd0);
    chk("abort_in_ready",  64'(in_ready),  64'd1);
    @(posedge clk);
    #1;
    send(2'b10, 7'h00, 3'd7, 64'hF0, 64'h3C, pack(64'h30, 4'b0000, 1'b0));
    drain("drain_after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
